// File: rtl/cbs_stream_engine_if.sv
// Pixel/result stream and weight-write bundle for the CBS stage.
// Latency: none, this is wiring only.
// Backpressure: none; the input stream is push-only and results are valid-qualified.
interface cbs_stream_engine_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 19,
  parameter int CNT_W  = 15
);
  logic                    in_valid;
  logic [DATA_W-1:0]       in_pixel;
  logic                    w_we;
  logic [3:0]              w_addr;
  logic [OUT_W-1:0]        w_data;
  logic [1:0]              act_mode;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_data;
  logic [CNT_W-1:0]        out_row;
  logic [CNT_W-1:0]        out_col;
  logic                    busy;
  logic                    frame_done;

  modport master (
    output in_valid, in_pixel, w_we, w_addr, w_data, act_mode,
    input  out_valid, out_data, out_row, out_col, busy, frame_done
  );

  modport slave (
    input  in_valid, in_pixel, w_we, w_addr, w_data, act_mode,
    output out_valid, out_data, out_row, out_col, busy, frame_done
  );
endinterface

// File: rtl/cbs_stream_engine.sv
// Streaming 3x3 conv + folded BN + activation over a raster pixel stream.
// Latency: result valid 5 cycles after the beat that completes its window.
// Backpressure: none; input gaps only delay results, pipeline is free-running.
module cbs_stream_engine #(
  parameter int DATA_W   = 8,
  parameter int COEF_W   = 8,
  parameter int BN_W     = 16,
  parameter int OUT_W    = 19,
  parameter int IMG_W    = 416,
  parameter int IMG_H    = 416,
  parameter int CNT_W    = 15,
  parameter int SHIFT    = 8,
  parameter int ACT_FRAC = 8
) (
  input logic          clk,
  input logic          reset,
  cbs_stream_engine_if.slave bus
);
  localparam int PROD_W = DATA_W + 1 + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 5;
  localparam int MUL_W  = ACC_W + BN_W;
  localparam int BNF_W  = MUL_W + 1;
  localparam int IDX_W  = $clog2(IMG_W);

  localparam logic signed [BN_W-1:0]  SCALE_RST = BN_W'(1 << SHIFT);
  localparam logic signed [BNF_W-1:0] SIX_ONE   = BNF_W'(6 << ACT_FRAC);
  localparam logic signed [BNF_W-1:0] SAT_HI    = BNF_W'((1 << (OUT_W-1)) - 1);
  localparam logic signed [BNF_W-1:0] SAT_LO    = ~SAT_HI;
  localparam logic signed [OUT_W-1:0] OUT_MAX   = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic signed [OUT_W-1:0] OUT_MIN   = {1'b1, {(OUT_W-1){1'b0}}};

  typedef struct packed {
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             last;
  } tag_t;

  logic [CNT_W-1:0]         in_col, in_row;
  logic signed [COEF_W-1:0] taps [9];
  logic signed [BN_W-1:0]   bn_scale;
  logic signed [OUT_W-1:0]  bn_bias;
  logic [DATA_W-1:0]        lb0 [IMG_W];
  logic [DATA_W-1:0]        lb1 [IMG_W];
  logic [DATA_W-1:0]        win [3][3];
  logic                     s1_vld, s2_vld, s3_vld, s4_vld;
  tag_t                     s1_tag, s2_tag, s3_tag, s4_tag;
  logic signed [PROD_W-1:0] s2_prod [9];
  logic signed [ACC_W-1:0]  s3_acc, acc_sum;
  logic signed [MUL_W-1:0]  bn_mul;
  logic signed [BNF_W-1:0]  s4_bn, bn_next, act_y;
  logic signed [OUT_W-1:0]  sat_y;
  logic [1:0]               pend, pend_next;
  logic [IDX_W-1:0]         col_idx;
  logic                     col_last, row_last, win_done, frame_start, frame_end;

  assign col_idx = in_col[IDX_W-1:0];

  // Raster position decode for the current beat and frame bookkeeping events.
  always_comb begin
    col_last    = (in_col == CNT_W'(IMG_W-1));
    row_last    = (in_row == CNT_W'(IMG_H-1));
    win_done    = (in_row >= CNT_W'(2)) && (in_col >= CNT_W'(2));
    frame_start = bus.in_valid && (in_row == '0) && (in_col == '0);
    frame_end   = s4_vld && s4_tag.last;
    pend_next   = pend + {1'b0, frame_start} - {1'b0, frame_end};
  end

  // Input raster counters, advanced only by accepted pixels.
  always_ff @(posedge clk) begin
    if (!reset) begin
      in_col <= '0;
      in_row <= '0;
    end else if (bus.in_valid) begin
      if (col_last) begin
        in_col <= '0;
        in_row <= row_last ? '0 : in_row + 1'b1;
      end else begin
        in_col <= in_col + 1'b1;
      end
    end
  end

  // Line buffers shift one line down in place; window shifts left and takes the new column.
  always_ff @(posedge clk) begin
    if (bus.in_valid) begin
      lb1[col_idx] <= lb0[col_idx];
      lb0[col_idx] <= bus.in_pixel;
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb1[col_idx];
      win[1][2] <= lb0[col_idx];
      win[2][2] <= bus.in_pixel;
    end
  end

  // Coefficient registers; writes only land between frames so a frame never sees mixed weights.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 9; i++) taps[i] <= '0;
      bn_scale <= SCALE_RST;
      bn_bias  <= '0;
    end else if (bus.w_we && !bus.busy) begin
      if (bus.w_addr <= 4'd8)       taps[bus.w_addr] <= bus.w_data[COEF_W-1:0];
      else if (bus.w_addr == 4'd9)  bn_scale <= bus.w_data[BN_W-1:0];
      else if (bus.w_addr == 4'd10) bn_bias  <= bus.w_data;
    end
  end

  // Adder tree over the nine registered products.
  always_comb begin
    acc_sum = '0;
    for (int i = 0; i < 9; i++) acc_sum = acc_sum + ACC_W'(s2_prod[i]);
  end

  // BN multiply keeps full precision; shift floors, bias is added before any clipping.
  always_comb begin
    bn_mul  = MUL_W'(s3_acc) * MUL_W'(bn_scale);
    bn_next = BNF_W'(bn_mul >>> SHIFT) + BNF_W'(bn_bias);
  end

  // Activation on the full-width BN value, then saturation to the output width.
  always_comb begin
    act_y = s4_bn;
    case (bus.act_mode)
      2'd1:    if (s4_bn < 0) act_y = '0;
      2'd2:    if (s4_bn < 0) act_y = s4_bn >>> 3;
      2'd3:    if (s4_bn < 0) act_y = '0; else if (s4_bn > SIX_ONE) act_y = SIX_ONE;
      default: act_y = s4_bn;
    endcase
    if (act_y > SAT_HI)      sat_y = OUT_MAX;
    else if (act_y < SAT_LO) sat_y = OUT_MIN;
    else                     sat_y = act_y[OUT_W-1:0];
  end

  // Pipeline S1..S5; the valid bit and the output tag ride alongside the data.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_vld <= 1'b0; s2_vld <= 1'b0; s3_vld <= 1'b0; s4_vld <= 1'b0;
      s1_tag <= '0;   s2_tag <= '0;   s3_tag <= '0;   s4_tag <= '0;
      for (int i = 0; i < 9; i++) s2_prod[i] <= '0;
      s3_acc         <= '0;
      s4_bn          <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_row    <= '0;
      bus.out_col    <= '0;
      bus.frame_done <= 1'b0;
    end else begin
      s1_vld     <= bus.in_valid && win_done;
      s1_tag.row <= in_row - CNT_W'(2);
      s1_tag.col <= in_col - CNT_W'(2);
      s1_tag.last <= row_last && col_last;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          s2_prod[r*3+c] <= PROD_W'($signed({1'b0, win[r][c]})) * PROD_W'(taps[r*3+c]);
      s2_vld <= s1_vld; s2_tag <= s1_tag;
      s3_acc <= acc_sum;
      s3_vld <= s2_vld; s3_tag <= s2_tag;
      s4_bn  <= bn_next;
      s4_vld <= s3_vld; s4_tag <= s3_tag;
      bus.out_valid  <= s4_vld;
      bus.out_data   <= sat_y;
      bus.out_row    <= s4_tag.row;
      bus.out_col    <= s4_tag.col;
      bus.frame_done <= frame_end;
    end
  end

  // Frames in flight: a new frame can start while the previous one drains, so busy follows a count.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pend     <= '0;
      bus.busy <= 1'b0;
    end else begin
      pend     <= pend_next;
      bus.busy <= (pend_next != '0);
    end
  end
endmodule

// File: tb/tb_cbs_stream_engine.sv
// Directed and random frames through two engines (SHIFT=8 and SHIFT=0) against a pixel-array model.
// Latency: every expected result carries the cycle it must appear in.
// Backpressure: none at the DUT; the bench inserts random input gaps.
module tb_cbs_stream_engine;
  localparam int DW = 8, CW = 8, BW = 16, OW = 19, W = 5, H = 4, CNTW = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, in_valid, w_we;
  logic [DW-1:0] in_pixel;
  logic [3:0]    w_addr;
  logic [OW-1:0] w_data;
  logic [1:0]    act_mode;

  cbs_stream_engine_if #(.DATA_W(DW), .OUT_W(OW), .CNT_W(CNTW)) bus8 ();
  cbs_stream_engine_if #(.DATA_W(DW), .OUT_W(OW), .CNT_W(CNTW)) bus0 ();

  assign bus8.in_valid = in_valid; assign bus8.in_pixel = in_pixel; assign bus8.w_we = w_we;
  assign bus8.w_addr = w_addr;     assign bus8.w_data = w_data;     assign bus8.act_mode = act_mode;
  assign bus0.in_valid = in_valid; assign bus0.in_pixel = in_pixel; assign bus0.w_we = w_we;
  assign bus0.w_addr = w_addr;     assign bus0.w_data = w_data;     assign bus0.act_mode = act_mode;

  cbs_stream_engine #(.DATA_W(DW), .COEF_W(CW), .BN_W(BW), .OUT_W(OW), .IMG_W(W), .IMG_H(H),
                      .CNT_W(CNTW), .SHIFT(8), .ACT_FRAC(8))
    u_dut8 (.clk(clk), .reset(reset), .bus(bus8));
  cbs_stream_engine #(.DATA_W(DW), .COEF_W(CW), .BN_W(BW), .OUT_W(OW), .IMG_W(W), .IMG_H(H),
                      .CNT_W(CNTW), .SHIFT(0), .ACT_FRAC(8))
    u_dut0 (.clk(clk), .reset(reset), .bus(bus0));

  typedef struct {
    longint data;
    int     row;
    int     col;
    int     due;
    bit     last;
  } exp_t;

  int     total = 0, bad = 0, cyc = 0;
  exp_t   q [2][$];
  longint obs [2][$];
  int     mtap [9];
  longint mscale [2];
  longint mbias;
  int     mmode, mr, mc;
  int     pixm [H][W];
  longint ev [6];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint o, input longint e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  function automatic int shv(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  function automatic longint fdiv(input longint a, input longint d);
    longint qt = a / d;
    if ((a % d != 0) && (a < 0)) qt = qt - 1;
    return qt;
  endfunction

  // Result for the window whose bottom-right pixel is (r,c), straight from the arithmetic rules.
  function automatic longint model(input int r, input int c, input int k);
    longint acc = 0, bn, y;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        acc += longint'(pixm[r-2+i][c-2+j]) * mtap[i*3+j];
    bn = fdiv(acc * mscale[k], longint'(1) << shv(k)) + mbias;
    case (mmode)
      0:       y = bn;
      1:       y = (bn < 0) ? 0 : bn;
      2:       y = (bn < 0) ? fdiv(bn, 8) : bn;
      default: y = (bn < 0) ? 0 : ((bn > 1536) ? 1536 : bn);
    endcase
    if (y > 262143)  y = 262143;
    if (y < -262144) y = -262144;
    return y;
  endfunction

  task automatic mon(input int k, input logic ov, input logic signed [OW-1:0] od,
                     input logic [CNTW-1:0] orow, input logic [CNTW-1:0] ocol,
                     input logic fd, input logic bz);
    exp_t e;
    if (ov) begin
      if (q[k].size() == 0) chk($sformatf("spurious%0d", k), 1, 0);
      else begin
        e = q[k].pop_front();
        chk($sformatf("data%0d_r%0dc%0d", k, e.row, e.col), longint'(od), e.data);
        chk($sformatf("row%0d", k), longint'(orow), e.row);
        chk($sformatf("col%0d", k), longint'(ocol), e.col);
        chk($sformatf("latency%0d", k), cyc, e.due);
        chk($sformatf("frame_done%0d", k), longint'(fd), longint'(e.last));
        if (e.last) chk($sformatf("busy_at_done%0d", k), longint'(bz), 0);
      end
      obs[k].push_back(longint'(od));
    end else if (q[k].size() != 0 && cyc > q[k][0].due) begin
      chk($sformatf("late%0d", k), cyc, q[k][0].due);
      void'(q[k].pop_front());
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      mon(0, bus8.out_valid, bus8.out_data, bus8.out_row, bus8.out_col, bus8.frame_done, bus8.busy);
      mon(1, bus0.out_valid, bus0.out_data, bus0.out_row, bus0.out_col, bus0.frame_done, bus0.busy);
    end
  end

  task automatic beat(input int p);
    exp_t e;
    @(negedge clk);
    in_valid = 1'b1;
    in_pixel = DW'(p);
    pixm[mr][mc] = p;
    if (mr >= 2 && mc >= 2) begin
      for (int k = 0; k < 2; k++) begin
        e.data = model(mr, mc, k); e.row = mr - 2; e.col = mc - 2;
        e.due = cyc + 5; e.last = (mr == H-1) && (mc == W-1);
        q[k].push_back(e);
      end
    end
    if (mc == W-1) begin mc = 0; mr = (mr == H-1) ? 0 : mr + 1; end
    else mc = mc + 1;
  endtask

  task automatic send_frame(input int pat, input int cval, input int gapmax);
    for (int i = 0; i < W*H; i++) begin
      int g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
      repeat (g) begin @(negedge clk); in_valid = 1'b0; end
      beat((pat == 0) ? cval : (pat == 1) ? i : int'($urandom_range(255, 0)));
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wr(input int addr, input longint val, input bit ignored);
    @(negedge clk);
    in_valid = 1'b0; w_we = 1'b1; w_addr = 4'(addr); w_data = OW'(val);
    if (!ignored) begin
      if (addr <= 8)       mtap[addr] = int'(val);
      else if (addr == 9)  begin mscale[0] = val; mscale[1] = val; end
      else if (addr == 10) mbias = val;
    end
    @(posedge clk);
    #1 w_we = 1'b0;
  endtask

  task automatic load_all(input int tv, input longint sc, input longint bi);
    for (int i = 0; i < 9; i++) wr(i, tv, 1'b0);
    wr(9, sc, 1'b0);
    wr(10, bi, 1'b0);
  endtask

  task automatic set_mode(input int m);
    @(negedge clk);
    act_mode = 2'(m);
    mmode = m;
  endtask

  task automatic clr();
    obs[0].delete();
    obs[1].delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q[0].size() + q[1].size()) != 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", q[0].size() + q[1].size(), 0);
    chk("busy_idle8", longint'(bus8.busy), 0);
    chk("busy_idle0", longint'(bus0.busy), 0);
  endtask

  task automatic chk_obs(input string tag, input int k, input longint v [6]);
    chk({tag, "_count"}, obs[k].size(), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("%s_%0d", tag, i), (i < obs[k].size()) ? obs[k][i] : -1, v[i]);
    clr();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0; w_we = 1'b0;
    q[0].delete(); q[1].delete();
    mr = 0; mc = 0;
    for (int i = 0; i < 9; i++) mtap[i] = 0;
    mscale[0] = 256; mscale[1] = 1; mbias = 0;
    @(negedge clk);
    chk("rst_out_valid", longint'(bus8.out_valid), 0);
    chk("rst_busy", longint'(bus8.busy), 0);
    chk("rst_frame_done", longint'(bus8.frame_done), 0);
    chk("rst_out_data", longint'(bus8.out_data), 0);
    chk("rst_out_row", longint'(bus8.out_row), 0);
    chk("rst_out_col", longint'(bus8.out_col), 0);
    chk("rst_out_valid0", longint'(bus0.out_valid), 0);
    chk("rst_busy0", longint'(bus0.busy), 0);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_pixel = '0; w_we = 1'b0; w_addr = '0; w_data = '0;
    act_mode = 2'd0; mmode = 0;
    reset_dut();

    // All-ones kernel on a flat image.
    set_mode(0); load_all(1, 256, 0); clr();
    send_frame(0, 10, 0); wait_idle();
    ev = '{90, 90, 90, 90, 90, 90}; chk_obs("flat", 0, ev);

    // Centre tap only on a ramp: result is the centre pixel.
    load_all(0, 256, 0); wr(4, 1, 1'b0); clr();
    send_frame(1, 0, 0); wait_idle();
    ev = '{6, 7, 8, 11, 12, 13}; chk_obs("centre", 0, ev);

    // Negative kernel through each activation.
    load_all(-1, 256, 0);
    for (int m = 0; m < 4; m++) begin
      set_mode(m); clr();
      send_frame(0, 255, 0); wait_idle();
      case (m)
        0:       ev = '{-2295, -2295, -2295, -2295, -2295, -2295};
        2:       ev = '{-287, -287, -287, -287, -287, -287};
        default: ev = '{0, 0, 0, 0, 0, 0};
      endcase
      chk_obs($sformatf("act%0d", m), 0, ev);
    end

    // Saturation and clamp on the SHIFT=0 engine.
    set_mode(0); load_all(127, 32767, 0); clr();
    send_frame(0, 255, 0); wait_idle();
    ev = '{262143, 262143, 262143, 262143, 262143, 262143}; chk_obs("sat", 1, ev);
    set_mode(3); load_all(0, 32767, 1000); clr();
    send_frame(0, 255, 0); wait_idle();
    ev = '{1000, 1000, 1000, 1000, 1000, 1000}; chk_obs("clamp_in", 1, ev);
    wr(10, 5000, 1'b0); clr();
    send_frame(0, 255, 0); wait_idle();
    ev = '{1536, 1536, 1536, 1536, 1536, 1536}; chk_obs("clamp_hi", 1, ev);

    // Centre tap again with random input gaps.
    set_mode(0); load_all(0, 256, 0); wr(4, 1, 1'b0); clr();
    send_frame(1, 0, 3); wait_idle();
    ev = '{6, 7, 8, 11, 12, 13}; chk_obs("gaps", 0, ev);

    // Random weights, BN, activation, pixels and gaps.
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 9; i++) wr(i, int'($urandom_range(255, 0)) - 128, 1'b0);
      wr(9, longint'($urandom_range(65535, 0)) - 32768, 1'b0);
      wr(10, longint'($urandom_range(200000, 0)) - 100000, 1'b0);
      set_mode(int'($urandom_range(3, 0)));
      send_frame(2, 0, 2); wait_idle();
    end
    clr();

    // Abandon a frame with reset, then check weights are frozen while busy.
    set_mode(0);
    for (int i = 0; i < 12; i++) beat(10);
    reset_dut();
    for (int i = 0; i < 9; i++) wr(i, 1, 1'b0);
    clr();
    for (int i = 0; i < 6; i++) beat(10);
    @(negedge clk);
    in_valid = 1'b0;
    chk("busy_mid", longint'(bus8.busy), 1);
    wr(0, 5, 1'b1);
    for (int i = 6; i < W*H; i++) beat(10);
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();
    ev = '{90, 90, 90, 90, 90, 90}; chk_obs("after_rst", 0, ev);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
